mult_controller: RTL
====================

Name: mult_controller

Overview:
Control unit that sequences the 4-bit shift-and-add multiplier datapath (Q, R, P, G registers, adder, iteration counter). It accepts a start request, issues the load/clear/shift/count strobes in the required order, and tests the multiplier LSB and the counter terminal flag each iteration. It signals busy and done to the surrounding top level. It is instantiated beside the datapath and drives all of the datapath's control inputs.

Parameters:
WIDTH, 4, operand width; also the number of add/shift iterations.
CNT_W, 3, width of the optional shadow iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
Ctrl_Clock  input  1  system clock, rising edge.
Ctrl_Reset_n  input  1  synchronous, active-low reset.
Ctrl_Start  input  1  level request; sampled only in IDLE.
Ctrl_Q_LSB  input  1  current multiplier LSB from the datapath.
Ctrl_Cnt_Out  input  1  datapath counter terminal flag; high when count == WIDTH-1.
Ctrl_Clear  output  1  active-high clear of P, G and counter.
Ctrl_Load_Q  output  1  load multiplier register.
Ctrl_Load_R  output  1  load multiplicand register.
Ctrl_Load_P  output  1  load adder sum into P.
Ctrl_Load_G  output  1  load adder carry into G.
Ctrl_Shift  output  1  shift G/P/Q right by one.
Ctrl_Cnt_En  output  1  increment the iteration counter.
Ctrl_Busy  output  1  high from INIT through the last SHIFT.
Ctrl_Done  output  1  one-cycle pulse; product valid.
Ctrl_Err  output  1  sequencing error flag; constant 0 unless the option is compiled in.

Behaviour:
- States: IDLE, INIT, TEST, SHIFT, DONE (plus ERROR with the option). State register is synchronous. Outputs are decoded combinationally from state (TEST is Mealy on Ctrl_Q_LSB).
- Reset (Ctrl_Reset_n=0 at a clock edge): state goes to IDLE; every output is 0 from that edge on. Reset mid-operation aborts immediately, and the datapath is left stale. Reset does not pulse Ctrl_Clear; the next run clears the datapath.
- IDLE: all outputs 0. If Ctrl_Start=1, go to INIT; otherwise stay.
- INIT (1 cycle): Ctrl_Clear=1, Ctrl_Load_Q=1, Ctrl_Load_R=1, Ctrl_Busy=1. Then go to TEST.
- TEST (1 cycle): Ctrl_Load_P=Ctrl_Load_G=Ctrl_Q_LSB, Ctrl_Busy=1. Then go to SHIFT.
- SHIFT (1 cycle): Ctrl_Shift=1, Ctrl_Cnt_En=1, Ctrl_Busy=1. If Ctrl_Cnt_Out=1, go to DONE; otherwise go to TEST.
- DONE (1 cycle): Ctrl_Done=1, Ctrl_Busy=0. Always go to IDLE. Ctrl_Start is ignored in DONE.
- Latency: Start sampled at edge 0, then INIT, then 2*WIDTH iteration cycles, then DONE. For WIDTH=4, Ctrl_Done is high in the 10th cycle after the sampling edge. Total period from Start to the next acceptance is 11 cycles.
- Ctrl_Start asserted while busy is ignored; no queuing.
- Start held continuously: a new run begins on the cycle after DONE (IDLE lasts one cycle).
- At most one of Ctrl_Shift and Ctrl_Load_P is asserted in any cycle. Ctrl_Clear is never asserted together with Ctrl_Shift.

Optional Feature:
MULT_CTRL_ERR_CHK_EN
- Defined:
  - An internal CNT_W-bit shadow counter clears in INIT and increments on each SHIFT.
  - If Ctrl_Cnt_Out=1 in SHIFT while shadow != WIDTH-1, go to ERROR.
  - If Ctrl_Cnt_Out=0 in SHIFT while shadow == WIDTH-1, also go to ERROR.
  - ERROR: all strobes 0, Ctrl_Busy=0, Ctrl_Err=1. The FSM leaves ERROR only through reset.
- Undefined: no shadow counter, no ERROR state, Ctrl_Err tied to 0.

Decomposition:
- Package mult_ctrl_pkg holds the state encoding localparams (IDLE, INIT, TEST, SHIFT, DONE, ERROR) and the WIDTH default.
- No sub-module is natural: the FSM plus the optional shadow counter fit in a single module.

Test Plan:
1. Q=13 (1101), R=11, Start pulse, behavioural datapath model attached -> Ctrl_Load_P pulses exactly 3 times, in iterations 1, 3 and 4. Ctrl_Done is high 10 cycles after the Start edge with product 143. Ctrl_Busy is high for exactly 9 cycles.
2. Q=0, R=15 -> Ctrl_Load_P is never asserted, product 0, Ctrl_Done still at cycle 10. Q=15, R=15 -> 4 Load_P pulses, product 225.
3. Start re-pulsed at cycles 3 and 7 of a run -> ignored: a single Ctrl_Done, and the strobe sequence is identical to the single-start case.
4. Ctrl_Reset_n=0 for one edge at cycle 5 -> all outputs 0 after that edge and state is IDLE. A following Start of Q=6, R=7 yields 42 with full latency.
5. Start held high for 30 cycles -> Ctrl_Done pulses at cycles 10, 21 and the next run restarts after each DONE. Ctrl_Clear pulses exactly once per run.
6. With MULT_CTRL_ERR_CHK_EN, force Ctrl_Cnt_Out=1 on the 2nd SHIFT -> ERROR state, Ctrl_Err=1, no Ctrl_Done, outputs frozen until reset. Without the macro, Ctrl_Err stays 0 and DONE follows the 2nd SHIFT.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg
//   Shared definitions for the shift-and-add multiplier control unit:
//   default operand width, shadow counter width and the FSM state encoding.
//   ERROR is only reachable when MULT_CTRL_ERR_CHK_EN is defined, but the
//   encoding is reserved in every build so the debug state output keeps a
//   stable meaning.
package mult_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int CNT_W_DEFAULT = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_TEST  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_INIT  = ST_INIT,
    S_TEST  = ST_TEST,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE,
    S_ERROR = ST_ERROR
  } state_t;

endpackage

// File: rtl/mult_controller.sv
// mult_controller
//   Sequencer for a WIDTH-bit shift-and-add multiplier datapath (Q, R, P, G
//   registers, adder, iteration counter). One run is:
//     INIT  : clear P/G/counter, load Q and R
//     TEST  : if the multiplier LSB is 1, load adder sum/carry into P/G
//     SHIFT : shift G/P/Q right, bump the counter; leave after WIDTH passes
//     DONE  : one-cycle product-valid pulse
//
//   Handshake: Ctrl_Start is a level request sampled only in IDLE; there is
//   no back-pressure and no queuing, so a request seen outside IDLE is
//   dropped. Ctrl_Done is a single-cycle valid pulse; the product in the
//   datapath is only guaranteed during that cycle. Ctrl_Busy covers INIT
//   through the last SHIFT.
//
//   Optional build macro MULT_CTRL_ERR_CHK_EN: adds a CNT_W-bit shadow
//   iteration counter that cross-checks the datapath terminal flag. Any
//   disagreement traps the FSM in ERROR (Ctrl_Err=1) until reset. Without
//   the macro Ctrl_Err is tied low.
//
// Ports
//   Ctrl_Clock    in   rising-edge clock
//   Ctrl_Reset_n  in   synchronous active-low reset
//   Ctrl_Start    in   run request (level, sampled in IDLE)
//   Ctrl_Q_LSB    in   current multiplier LSB
//   Ctrl_Cnt_Out  in   datapath counter terminal flag (count == WIDTH-1)
//   Ctrl_Clear    out  clear P, G and counter
//   Ctrl_Load_Q   out  load multiplier register
//   Ctrl_Load_R   out  load multiplicand register
//   Ctrl_Load_P   out  load adder sum into P
//   Ctrl_Load_G   out  load adder carry into G
//   Ctrl_Shift    out  shift G/P/Q right by one
//   Ctrl_Cnt_En   out  increment iteration counter
//   Ctrl_Busy     out  run in progress (INIT .. last SHIFT)
//   Ctrl_Done     out  one-cycle product-valid pulse
//   Ctrl_Err      out  sequencing error flag
//   Ctrl_State    out  debug view of the FSM state register
import mult_ctrl_pkg::*;

module mult_controller #(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic       Ctrl_Clock,
  input  logic       Ctrl_Reset_n,
  input  logic       Ctrl_Start,
  input  logic       Ctrl_Q_LSB,
  input  logic       Ctrl_Cnt_Out,
  output logic       Ctrl_Clear,
  output logic       Ctrl_Load_Q,
  output logic       Ctrl_Load_R,
  output logic       Ctrl_Load_P,
  output logic       Ctrl_Load_G,
  output logic       Ctrl_Shift,
  output logic       Ctrl_Cnt_En,
  output logic       Ctrl_Busy,
  output logic       Ctrl_Done,
  output logic       Ctrl_Err,
  output logic [2:0] Ctrl_State
);

  state_t state;
  state_t next_state;

  // High in SHIFT when the shadow counter disagrees with the datapath flag.
  logic cnt_mismatch;

  always_ff @(posedge Ctrl_Clock) begin
    if (!Ctrl_Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

`ifdef MULT_CTRL_ERR_CHK_EN
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] shadow_cnt;

  // Mirrors the datapath counter: zeroed with the datapath clear in INIT,
  // advanced alongside Ctrl_Cnt_En in SHIFT.
  always_ff @(posedge Ctrl_Clock) begin
    if (!Ctrl_Reset_n) begin
      shadow_cnt <= '0;
    end else if (state == S_INIT) begin
      shadow_cnt <= '0;
    end else if (state == S_SHIFT) begin
      shadow_cnt <= shadow_cnt + 1'b1;
    end
  end

  always_comb begin
    cnt_mismatch = 1'b0;
    if (state == S_SHIFT) begin
      cnt_mismatch = (Ctrl_Cnt_Out != (shadow_cnt == LAST_ITER));
    end
  end
`else
  // Parameters only matter to the shadow counter; keep them referenced.
  logic unused_cfg;
  assign unused_cfg   = (WIDTH > 0) ^ (CNT_W > 0);
  assign cnt_mismatch = 1'b0;
`endif

  // Next-state and output decode. Everything is a function of state except
  // the TEST-state P/G loads, which follow the multiplier LSB directly.
  always_comb begin
    next_state  = state;
    Ctrl_Clear  = 1'b0;
    Ctrl_Load_Q = 1'b0;
    Ctrl_Load_R = 1'b0;
    Ctrl_Load_P = 1'b0;
    Ctrl_Load_G = 1'b0;
    Ctrl_Shift  = 1'b0;
    Ctrl_Cnt_En = 1'b0;
    Ctrl_Busy   = 1'b0;
    Ctrl_Done   = 1'b0;
    Ctrl_Err    = 1'b0;

    case (state)
      S_IDLE: begin
        if (Ctrl_Start) begin
          next_state = S_INIT;
        end
      end

      S_INIT: begin
        Ctrl_Clear  = 1'b1;
        Ctrl_Load_Q = 1'b1;
        Ctrl_Load_R = 1'b1;
        Ctrl_Busy   = 1'b1;
        next_state  = S_TEST;
      end

      S_TEST: begin
        Ctrl_Load_P = Ctrl_Q_LSB;
        Ctrl_Load_G = Ctrl_Q_LSB;
        Ctrl_Busy   = 1'b1;
        next_state  = S_SHIFT;
      end

      S_SHIFT: begin
        Ctrl_Shift  = 1'b1;
        Ctrl_Cnt_En = 1'b1;
        Ctrl_Busy   = 1'b1;
        if (cnt_mismatch) begin
          next_state = S_ERROR;
        end else if (Ctrl_Cnt_Out) begin
          next_state = S_DONE;
        end else begin
          next_state = S_TEST;
        end
      end

      // Start is deliberately not looked at here: IDLE always lasts at
      // least one cycle between runs.
      S_DONE: begin
        Ctrl_Done  = 1'b1;
        next_state = S_IDLE;
      end

`ifdef MULT_CTRL_ERR_CHK_EN
      // Sticky trap: only reset leaves it.
      S_ERROR: begin
        Ctrl_Err   = 1'b1;
        next_state = S_ERROR;
      end
`endif

      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  assign Ctrl_State = state;

endmodule
